// File: rtl/ram_arbiter_pkg.sv
// ============================================================
// Package : ram_arbiter_pkg
// Shared bus encodings: access modes and arbiter FSM states.
// Rev     : 1.0
// ============================================================
`default_nettype none

package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================
// Module : rr_arbiter2
// Two-way round-robin grant; last=1 means master 1 won last time.
// Rev    : 1.0
// ============================================================
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================
// Module : ram_arbiter
// Two-master round-robin arbiter in front of a fixed-latency RAM.
// Rev    : 1.0
// ============================================================
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [1:0]  m0_mode,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic [1:0]  m1_mode,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [1:0]  ram_mode,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [3:0] c_last_cnt = 4'(RAM_LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last;       // index of the master granted most recently
  mode_t       r_ram_mode;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_wdata;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        r_m0_ack;
  logic        r_m1_ack;

  logic [1:0]  w_req;
  logic [1:0]  w_grant;

  assign w_req = {m1_req && (m1_mode != MODE_IDLE),
                  m0_req && (m0_mode != MODE_IDLE)};

  rr_arbiter2 u_rr (
    .req   (w_req),
    .last  (r_last),
    .grant (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_last      <= 1'b1;
      r_ram_mode  <= MODE_IDLE;
      r_ram_addr  <= 32'd0;
      r_ram_wdata <= 32'd0;
      r_m0_rdata  <= 32'd0;
      r_m1_rdata  <= 32'd0;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant != 2'b00) begin
            // ram_* registers double as the latched copy of the request
            r_last      <= w_grant[1];
            r_ram_mode  <= w_grant[1] ? mode_t'(m1_mode) : mode_t'(m0_mode);
            r_ram_addr  <= w_grant[1] ? m1_addr  : m0_addr;
            r_ram_wdata <= w_grant[1] ? m1_wdata : m0_wdata;
            r_cnt       <= 4'd0;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == c_last_cnt) begin
            if (r_ram_mode == MODE_READ) begin
              if (r_last) r_m1_rdata <= ram_rdata;
              else        r_m0_rdata <= ram_rdata;
            end
            r_ram_mode <= MODE_IDLE;
            r_m0_ack   <= ~r_last;
            r_m1_ack   <= r_last;
            r_cnt      <= 4'd0;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_mode  = r_ram_mode;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign m0_ack    = r_m0_ack;
  assign m1_ack    = r_m1_ack;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================
// Module : tb_ram_arbiter
// Cycle vectors against a latency-1 arbiter plus a latency-3 sequence.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_ram_arbiter;

  localparam logic [1:0]  MI = 2'b00;
  localparam logic [1:0]  MR = 2'b01;
  localparam logic [1:0]  MW = 2'b10;
  localparam logic [31:0] A  = 32'h8000_2000;
  localparam logic [31:0] B  = 32'h8000_0010;
  localparam logic [31:0] X  = 32'h1234_5678;
  localparam logic [31:0] D  = 32'hDEAD_BEEF;
  localparam logic [31:0] F  = 32'hFFFF_FFFF;
  localparam int NV = 34;

  logic        clk;
  logic        rst;
  logic        m0_req, m1_req;
  logic [1:0]  m0_mode, m1_mode;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        m0_ack, m1_ack;
  logic [1:0]  ram_mode;
  logic [31:0] m0_rdata_l3, m1_rdata_l3, ram_addr_l3, ram_wdata_l3, ram_rdata_l3;
  logic        m0_ack_l3, m1_ack_l3;
  logic [1:0]  ram_mode_l3;

  int n_cmp = 0;
  int n_bad = 0;

  ram_arbiter #(.RAM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_mode(m0_mode), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_mode(ram_mode), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_arbiter #(.RAM_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_mode(m0_mode), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata_l3), .m0_ack(m0_ack_l3),
    .m1_req(m1_req), .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata_l3), .m1_ack(m1_ack_l3),
    .ram_mode(ram_mode_l3), .ram_addr(ram_addr_l3), .ram_wdata(ram_wdata_l3),
    .ram_rdata(ram_rdata_l3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mock RAM for the latency-1 instance, word-indexed by addr[7:2]
  logic [31:0] mem [64];
  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'd0;
    mem[0] = D;
  end
  always @(posedge clk) begin
    if (ram_mode == MW) mem[ram_addr[7:2]] = ram_wdata;
  end
  assign ram_rdata = mem[ram_addr[7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    n_cmp++;
    if ((m0_ack === 1'b1 && m1_ack === 1'b1) || (m0_ack_l3 === 1'b1 && m1_ack_l3 === 1'b1)) begin
      n_bad++;
      $display("FAIL dual_ack at %0t: got both acks high, expected at most one", $time);
    end
  end

  typedef struct {
    logic        rst;
    logic        q0;
    logic [1:0]  o0;
    logic [31:0] a0, d0;
    logic        q1;
    logic [1:0]  o1;
    logic [31:0] a1, d1;
    logic [1:0]  emode;
    logic [31:0] eaddr, ewd;
    logic        eack0, eack1;
    logic [31:0] erd0, erd1;
  } vec_t;

  function automatic vec_t mk(input int rs, input int q0, input logic [1:0] o0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input int q1, input logic [1:0] o1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic [1:0] em, input logic [31:0] ea, input logic [31:0] ew,
                              input int k0, input int k1,
                              input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v.rst = (rs != 0); v.q0 = (q0 != 0); v.o0 = o0; v.a0 = a0; v.d0 = d0;
    v.q1 = (q1 != 0); v.o1 = o1; v.a1 = a1; v.d1 = d1;
    v.emode = em; v.eaddr = ea; v.ewd = ew;
    v.eack0 = (k0 != 0); v.eack1 = (k1 != 0); v.erd0 = r0; v.erd1 = r1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vt [NV];

  initial begin
    //           rst m0: q  mode a  d   m1: q mode a  d   expected: mode addr wd ack0 ack1 rd0 rd1
    vt[0]  = mk(1, 0,MI,0,0, 0,MI,0,0, MI,0,0,0,0,0,0);
    vt[1]  = mk(0, 1,MR,A,0, 0,MI,0,0, MR,A,0,0,0,0,0);
    vt[2]  = mk(0, 1,MR,A,0, 0,MI,0,0, MI,A,0,1,0,D,0);
    vt[3]  = mk(0, 0,MI,0,0, 0,MI,0,0, MI,A,0,0,0,D,0);
    vt[4]  = mk(0, 0,MI,0,0, 1,MW,B,X, MW,B,X,0,0,D,0);
    vt[5]  = mk(0, 0,MI,0,0, 1,MW,B,X, MI,B,X,0,1,D,0);
    vt[6]  = mk(0, 0,MI,0,0, 0,MI,0,0, MI,B,X,0,0,D,0);
    vt[7]  = mk(0, 1,MR,B,0, 0,MI,0,0, MR,B,0,0,0,D,0);
    vt[8]  = mk(0, 1,MR,B,0, 0,MI,0,0, MI,B,0,1,0,X,0);
    vt[9]  = mk(0, 0,MI,0,0, 0,MI,0,0, MI,B,0,0,0,X,0);
    vt[10] = mk(1, 0,MI,0,0, 0,MI,0,0, MI,0,0,0,0,0,0);
    // both masters hold READ requests: m0, m1, m0, m1
    vt[11] = mk(0, 1,MR,A,0, 1,MR,B,0, MR,A,0,0,0,0,0);
    vt[12] = mk(0, 1,MR,A,0, 1,MR,B,0, MI,A,0,1,0,D,0);
    vt[13] = mk(0, 1,MR,A,0, 1,MR,B,0, MI,A,0,0,0,D,0);
    vt[14] = mk(0, 1,MR,A,0, 1,MR,B,0, MR,B,0,0,0,D,0);
    vt[15] = mk(0, 1,MR,A,0, 1,MR,B,0, MI,B,0,0,1,D,X);
    vt[16] = mk(0, 1,MR,A,0, 1,MR,B,0, MI,B,0,0,0,D,X);
    vt[17] = mk(0, 1,MR,A,0, 1,MR,B,0, MR,A,0,0,0,D,X);
    vt[18] = mk(0, 1,MR,A,0, 1,MR,B,0, MI,A,0,1,0,D,X);
    vt[19] = mk(0, 1,MR,A,0, 1,MR,B,0, MI,A,0,0,0,D,X);
    vt[20] = mk(0, 1,MR,A,0, 1,MR,B,0, MR,B,0,0,0,D,X);
    vt[21] = mk(0, 1,MR,A,0, 1,MR,B,0, MI,B,0,0,1,D,X);
    vt[22] = mk(0, 0,MI,0,0, 0,MI,0,0, MI,B,0,0,0,D,X);
    // m0 withdraws and scrambles its inputs right after the grant
    vt[23] = mk(0, 1,MR,B,0, 0,MI,0,0, MR,B,0,0,0,D,X);
    vt[24] = mk(0, 0,MI,F,F, 0,MI,0,0, MI,B,0,1,0,X,X);
    vt[25] = mk(0, 0,MI,0,0, 0,MI,0,0, MI,B,0,0,0,X,X);
    vt[26] = mk(0, 0,MI,0,0, 0,MI,0,0, MI,B,0,0,0,X,X);
    // reset lands mid-access; m1 keeps requesting and is served afresh
    vt[27] = mk(0, 0,MI,0,0, 1,MR,A,0, MR,A,0,0,0,X,X);
    vt[28] = mk(1, 0,MI,0,0, 1,MR,A,0, MI,0,0,0,0,0,0);
    vt[29] = mk(0, 0,MI,0,0, 1,MR,A,0, MR,A,0,0,0,0,0);
    vt[30] = mk(0, 0,MI,0,0, 1,MR,A,0, MI,A,0,0,1,0,D);
    vt[31] = mk(0, 0,MI,0,0, 0,MI,0,0, MI,A,0,0,0,0,D);
    // req with IDLE mode is not a request
    vt[32] = mk(0, 1,MI,B,0, 0,MR,B,0, MI,A,0,0,0,0,D);
    vt[33] = mk(0, 0,MI,0,0, 0,MI,0,0, MI,A,0,0,0,0,D);

    ram_rdata_l3 = 32'd0;
    for (int i = 0; i < NV; i++) begin
      rst = vt[i].rst;
      m0_req = vt[i].q0; m0_mode = vt[i].o0; m0_addr = vt[i].a0; m0_wdata = vt[i].d0;
      m1_req = vt[i].q1; m1_mode = vt[i].o1; m1_addr = vt[i].a1; m1_wdata = vt[i].d1;
      step();
      chk($sformatf("v%0d ram_mode", i), {30'd0, ram_mode}, {30'd0, vt[i].emode});
      chk($sformatf("v%0d ram_addr", i), ram_addr, vt[i].eaddr);
      chk($sformatf("v%0d ram_wdata", i), ram_wdata, vt[i].ewd);
      chk($sformatf("v%0d m0_ack", i), {31'd0, m0_ack}, {31'd0, vt[i].eack0});
      chk($sformatf("v%0d m1_ack", i), {31'd0, m1_ack}, {31'd0, vt[i].eack1});
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, vt[i].erd0);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, vt[i].erd1);
    end

    // RAM_LATENCY=3: request seen at N, held N+1..N+3, ack at N+4
    rst = 1'b1;
    m0_req = 1'b0; m0_mode = MI; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_mode = MI; m1_addr = 32'd0; m1_wdata = 32'd0;
    step();
    chk("l3 reset ram_mode", {30'd0, ram_mode_l3}, {30'd0, MI});
    chk("l3 reset ram_addr", ram_addr_l3, 32'd0);
    chk("l3 reset m0_rdata", m0_rdata_l3, 32'd0);
    rst = 1'b0;
    m0_req = 1'b1; m0_mode = MR; m0_addr = A; m0_wdata = 32'h0000_00AA;
    step();
    chk("l3 n+1 ram_mode", {30'd0, ram_mode_l3}, {30'd0, MR});
    chk("l3 n+1 ram_addr", ram_addr_l3, A);
    chk("l3 n+1 ram_wdata", ram_wdata_l3, 32'h0000_00AA);
    chk("l3 n+1 m0_ack", {31'd0, m0_ack_l3}, 32'd0);
    ram_rdata_l3 = 32'h1111_1111;
    m0_addr = F;
    step();
    chk("l3 n+2 ram_mode", {30'd0, ram_mode_l3}, {30'd0, MR});
    chk("l3 n+2 ram_addr", ram_addr_l3, A);
    chk("l3 n+2 m0_ack", {31'd0, m0_ack_l3}, 32'd0);
    ram_rdata_l3 = 32'h2222_2222;
    step();
    chk("l3 n+3 ram_mode", {30'd0, ram_mode_l3}, {30'd0, MR});
    chk("l3 n+3 ram_addr", ram_addr_l3, A);
    chk("l3 n+3 m0_ack", {31'd0, m0_ack_l3}, 32'd0);
    ram_rdata_l3 = 32'h3333_3333;
    step();
    chk("l3 n+4 m0_ack", {31'd0, m0_ack_l3}, 32'd1);
    chk("l3 n+4 m1_ack", {31'd0, m1_ack_l3}, 32'd0);
    chk("l3 n+4 ram_mode", {30'd0, ram_mode_l3}, {30'd0, MI});
    chk("l3 n+4 m0_rdata", m0_rdata_l3, 32'h3333_3333);
    m0_req = 1'b0; m0_mode = MI;
    ram_rdata_l3 = 32'h4444_4444;
    step();
    chk("l3 n+5 m0_ack", {31'd0, m0_ack_l3}, 32'd0);
    chk("l3 n+5 m0_rdata", m0_rdata_l3, 32'h3333_3333);
    chk("l3 n+5 ram_addr", ram_addr_l3, A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_LATENCY, default 1, the number of cycles ram_mode/ram_addr/ram_wdata are held before ram_rdata is sampled (legal range 1-15).
REQ-002 The block SHALL have the following ports:
- clk  input  1  the single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- m0_req  input  1  master 0 (CPU) request; held until m0_ack.
- m0_mode  input  2  master 0 access mode: IDLE, READ or WRITE.
- m0_addr  input  32  master 0 byte address.
- m0_wdata  input  32  master 0 write data.
- m0_rdata  output  32  master 0 read data.
- m0_ack  output  1  master 0 completion pulse.
- m1_req, m1_mode, m1_addr, m1_wdata, m1_rdata, m1_ack  same as master 0; master 1 is the loader/DMA port.
- ram_mode  output  2  RAM access mode.
- ram_addr  output  32  RAM address.
- ram_wdata  output  32  RAM write data.
- ram_rdata  input  32  RAM read data.

Function
REQ-003 A master SHALL count as requesting only when mX_req=1 and mX_mode is not IDLE.
REQ-004 The FSM SHALL have exactly three states: S_IDLE, S_ACCESS and S_DONE.
REQ-005 In S_IDLE with at least one master requesting, the block SHALL grant one master, latch its mode/addr/wdata and go to S_ACCESS on the next edge.
REQ-006 With no master requesting, the block SHALL stay in S_IDLE.
REQ-007 Arbitration SHALL be round-robin: if both masters request, the master not granted most recently wins; a single requester always wins.
REQ-008 In S_ACCESS, ram_mode/ram_addr/ram_wdata SHALL carry the latched values unchanged for exactly RAM_LATENCY cycles, counted by a latency counter.
REQ-009 On the last S_ACCESS cycle, the block SHALL sample ram_rdata into the granted master's rdata register for a READ; for a WRITE it SHALL leave that register unchanged.
REQ-010 The FSM SHALL go S_ACCESS -> S_DONE after the last S_ACCESS cycle.
REQ-011 In S_DONE, the granted master's ack SHALL be 1 for exactly one cycle, and ram_mode SHALL be IDLE.
REQ-012 The FSM SHALL go S_DONE -> S_IDLE unconditionally.
REQ-013 Transaction latency SHALL be: request seen in S_IDLE at cycle N -> ack at cycle N+1+RAM_LATENCY; a new grant no earlier than N+2+RAM_LATENCY.
REQ-014 mX_rdata SHALL stay stable from its ack cycle until that master's next READ completes.
REQ-015 Changes to a granted master's req/mode/addr/wdata after grant SHALL NOT affect the transaction in flight; if req drops mid-transaction, the access still completes and ack still pulses.
REQ-016 A non-granted master's request SHALL wait without loss; no ack SHALL go to a master that did not hold the grant.
REQ-017 m0_ack and m1_ack SHALL never be 1 in the same cycle.
REQ-018 Outside S_ACCESS, ram_mode SHALL be IDLE; ram_addr and ram_wdata SHALL keep their last values.

Reset
REQ-019 On rst=1 at a rising edge, the block SHALL enter S_IDLE.
REQ-020 On reset, ram_mode SHALL be IDLE, ram_addr/ram_wdata SHALL be 0, m0/m1_rdata SHALL be 0, both acks SHALL be 0, and the latency counter SHALL be 0.
REQ-021 On reset, the round-robin pointer SHALL favour m0 (m1 treated as last granted).
REQ-022 Reset during S_ACCESS or S_DONE SHALL abort the transaction with no ack issued; masters SHALL re-issue their requests.

Structure
REQ-023 The 2-bit mode encoding (IDLE=00, READ=01, WRITE=10) and the state enum SHALL be in the shared bus package also used by IOManager and MultiCycleCPU.
REQ-024 The round-robin grant logic SHALL be one sub-module, rr_arbiter2 (inputs: req[1:0], last grant; output: one-hot grant), with the FSM and datapath in ram_arbiter.

Verification
REQ-025 The bench SHALL cover the following scenarios against a MockRam-style model with RAM_LATENCY=1:
- m0 READ 0x80002000, RAM returns 0xDEADBEEF -> m0_ack 2 cycles after the request is seen, m0_rdata=0xDEADBEEF, m1_ack stays 0.
- m1 WRITE 0x80000010 data 0x12345678 -> ram_mode=WRITE with that addr/data for 1 cycle; then m1_ack; a later READ of the same address returns 0x12345678.
- Both masters request a READ continuously right after reset -> grant order m0, m1, m0, m1; acks 3 cycles apart and never simultaneous.
- m0 drops req the cycle after grant -> the access still completes with an m0_ack pulse; no spurious second access.
- rst asserted during S_ACCESS -> no ack, all outputs at reset values next cycle, and a fresh request is served normally.
- RAM_LATENCY=3, m0 READ -> ram signals held for 3 cycles, ack at N+4, and rdata equals RAM data at the last S_ACCESS cycle.
